alu_chain_sequencer: RTL
========================

# alu_chain_sequencer

Multi-precision add/subtract sequencer that sits directly in front of the 8-bit ALU and behind it. It accepts two `Words`-wide operands and feeds them to the ALU one word at a time, LSB first. Between words it chains the ALU carry-out back into the carry-in. It assembles the result words and the final O,N,C,Z flags. It is the block the datapath controller uses for 16/32-bit arithmetic on the single narrow ALU.

## Interface
Parameters:
- `BitWidth`, 8: ALU word width.
- `Words`, 4: number of words per operand. Must be ≥ 1.
- `FlagBits`, 4: flag vector width, ordered O,N,C,Z (bits 3..0).

Ports:
- `Clk`  in  1: single clock, rising edge.
- `Reset`  in  1: asynchronous, active-high.
- `Start`  in  1: request a new operation. Sampled only in IDLE.
- `Op`  in  1: 0 = add, 1 = subtract (OpA − OpB).
- `OpA`  in  BitWidth*Words: operand A.
- `OpB`  in  BitWidth*Words: operand B.
- `Busy`  out  1: high while an operation is in progress.
- `Done`  out  1: one-cycle pulse when Result/Flags are valid.
- `Result`  out  BitWidth*Words: assembled result.
- `Flags`  out  FlagBits: final {V,N,C,Z}.
- `AluA`  out  BitWidth: word to ALU A.
- `AluB`  out  BitWidth: word to ALU B.
- `AluFuncOp`  out  4: ALU opcode. Constant 4'b0000 (add_op).
- `AluIFlags`  out  FlagBits: ALU input flags. Only bit 1 (carry) is non-zero.
- `AluOE`  out  1: ALU output enable, active low.
- `AluY`  in  BitWidth: ALU result.
- `AluOFlags`  in  FlagBits: ALU flags {V,N,C,Z}.

## Operation
- States are IDLE, EXEC and DONE.
- **IDLE:**
  - `Busy`=0, `AluOE`=1.
  - On a `Clk` edge with `Start`=1, latch `OpA`, `OpB` and `Op` into shadow registers.
  - Set `Index` to 0, `CarryReg` to `Op`, `ZeroAcc` to 1, then go to EXEC.
- **EXEC:**
  - `Busy`=1, `AluOE`=0.
  - `AluA` = A word[`Index`].
  - `AluB` = B word[`Index`] when `Op`=0, and ~B word[`Index`] when `Op`=1.
  - `AluIFlags` = {0,0,`CarryReg`,0}.
  - Subtraction is performed as A + ~B + 1 through add_op. The ALU's sub_op is never used.
  - On each edge, `Result` word[`Index`] ← `AluY`, `CarryReg` ← `AluOFlags`[1], `ZeroAcc` ← `ZeroAcc` & `AluOFlags`[0].
  - If `Index` == `Words`−1, go to DONE. Otherwise `Index`++.
- **DONE:**
  - `Done`=1, `Busy`=0, `AluOE`=1.
  - `Flags` = {last-word V, last-word N, final carry, `ZeroAcc`}, registered on the final EXEC edge.
  - Next edge returns to IDLE unconditionally.
- `AluA`, `AluB` and `AluIFlags` are driven to 0 outside EXEC.
- C semantics: for add, C=1 means unsigned overflow. For subtract, C=1 means no borrow (A ≥ B unsigned).
- V and N come from the most significant word only. Z is 1 only if every word is zero.
- `Result` and `Flags` hold their value from DONE until the next accepted `Start`. They are not cleared at `Start`.
- `Start` while in EXEC or DONE is ignored and not queued.
- `OpA`, `OpB` and `Op` changing after acceptance have no effect.
- With `Words`=1 there is a single EXEC cycle.

## Timing
- Reset values: `Busy`=0, `Done`=0, `Result`=0, `Flags`=0, `AluOE`=1, `AluA`=0, `AluB`=0, `AluIFlags`=0, `AluFuncOp`=4'b0000. State is IDLE and `Index`=0.
- Reset at any point, including mid-EXEC, applies these values immediately (asynchronously). The partial result is discarded.
- Let edge k be the edge that samples `Start`=1.
  - EXEC occupies the cycles after edges k .. k+`Words`−1.
  - The capture of word i occurs at edge k+1+i.
  - `Done` is high for exactly the cycle after edge k+`Words`.
  - Latency from `Start` sample to `Done` is `Words` cycles. The next `Start` can be accepted at edge k+`Words`+2.
- The ALU's internal propagation delay plus its tri-state delay must settle within one `Clk` period. The sequencer samples `AluY` and `AluOFlags` at the edge ending each EXEC cycle.
- All outputs are registered or decoded from state only. No combinational path exists from `Start` to any output.

## Test plan
- **Add with carry chain.** Add 0x000000FF + 0x00000001 → `Result`=0x00000100, `Flags`=0000. Word 1's `AluIFlags`[1]=1 is visible during its EXEC cycle.
- **Add wrap-around to zero.** Add 0xFFFFFFFF + 0x00000001 → `Result`=0x00000000, Z=1, C=1, N=0, V=0.
- **Subtract with borrow.** Subtract 0x00000005 − 0x00000007 → `Result`=0xFFFFFFFE, N=1, C=0, Z=0, V=0. Word 0 shows `AluB`=0xF8 and carry-in 1.
- **Signed overflow.** Add 0x7FFFFFFF + 0x00000001 → `Result`=0x80000000, V=1, N=1, C=0, Z=0. Then subtract 0x80000000 − 0x00000001 → 0x7FFFFFFF, V=1, C=1.
- **Handshake timing.** A one-cycle `Start` pulse → `Busy` high for 4 cycles, `Done` high exactly 4 edges later for 1 cycle, and `AluOE` low only during those 4 cycles. A second `Start` held high throughout `Busy` is ignored until IDLE is reached.
- **Reset mid-operation.** Assert `Reset` during the second EXEC cycle → `Busy`, `Done`, `Result` and `Flags` read 0 and `AluOE`=1 immediately, with no `Done` pulse. A subsequent add 0x00000002 + 0x00000003 → 0x00000005 is correct.

Source files
------------

// File: rtl/alu_chain_sequencer.sv
// rtl/alu_chain_sequencer.sv - multi-word add/subtract sequencer around a narrow ALU
//
// Purpose:
//   Breaks a Words x BitWidth add or subtract into BitWidth-wide ALU passes,
//   least significant word first. The ALU carry-out of each pass is fed back
//   as the carry-in of the next pass. The result words are assembled, and the
//   final O,N,C,Z flags are produced. Subtraction is A + ~B + 1 through the
//   ALU add opcode: the initial carry-in is 1 and the B word is inverted.
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous active-high reset
//   Start      in   request a new operation (sampled only while idle)
//   Op         in   0 = add, 1 = subtract (OpA - OpB)
//   OpA, OpB   in   Words*BitWidth operands
//   Busy       out  high while words are being fed to the ALU
//   Done       out  one-cycle pulse, Result/Flags valid
//   Result     out  assembled result, held until the next accepted Start
//   Flags      out  {V,N,C,Z} of the whole operation
//   AluA/AluB  out  current word to the ALU (zero outside EXEC)
//   AluFuncOp  out  ALU opcode, always add
//   AluIFlags  out  ALU input flags, only the carry bit (bit 1) is used
//   AluOE      out  ALU output enable, active low
//   AluY       in   ALU result word
//   AluOFlags  in   ALU flags {V,N,C,Z} for the current word

module alu_chain_sequencer #(
  parameter int BitWidth = 8,
  parameter int Words    = 4,
  parameter int FlagBits = 4
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic                      Start,
  input  logic                      Op,
  input  logic [BitWidth*Words-1:0] OpA,
  input  logic [BitWidth*Words-1:0] OpB,
  output logic                      Busy,
  output logic                      Done,
  output logic [BitWidth*Words-1:0] Result,
  output logic [FlagBits-1:0]       Flags,
  output logic [BitWidth-1:0]       AluA,
  output logic [BitWidth-1:0]       AluB,
  output logic [3:0]                AluFuncOp,
  output logic [FlagBits-1:0]       AluIFlags,
  output logic                      AluOE,
  input  logic [BitWidth-1:0]       AluY,
  input  logic [FlagBits-1:0]       AluOFlags
);

  // With a single word the index is still one bit wide, so the counter
  // declaration stays legal.
  localparam int IdxW = (Words > 1) ? $clog2(Words) : 1;
  localparam int TotW = BitWidth * Words;

  // Positions inside the flag vector.
  localparam int FlagZ = 0;
  localparam int FlagC = 1;
  localparam int FlagN = 2;
  localparam int FlagV = 3;

  localparam logic [3:0] AddOp = 4'b0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [IdxW-1:0]     index_q, index_d;
  logic [TotW-1:0]     a_q, a_d;
  logic [TotW-1:0]     b_q, b_d;
  logic                op_q, op_d;
  logic                carry_q, carry_d;
  logic                zero_acc_q, zero_acc_d;
  logic [TotW-1:0]     result_q, result_d;
  logic [FlagBits-1:0] flags_q, flags_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                alu_oe_q, alu_oe_d;

  logic [BitWidth-1:0] a_word;
  logic [BitWidth-1:0] b_word;
  logic                last_word;

  // Select the word currently addressed by the index. A loop over constant
  // slices keeps the mux free of variable-width arithmetic.
  always_comb begin
    a_word = '0;
    b_word = '0;
    for (int w = 0; w < Words; w++) begin
      if (index_q == IdxW'(w)) begin
        a_word = a_q[w*BitWidth +: BitWidth];
        b_word = b_q[w*BitWidth +: BitWidth];
      end
    end
  end

  assign last_word = (index_q == IdxW'(Words - 1));

  // The ALU-facing words come only from registered state and shadow
  // operands. Start has no combinational path to any output.
  always_comb begin
    AluA      = '0;
    AluB      = '0;
    AluIFlags = '0;
    if (state_q == EXEC) begin
      AluA             = a_word;
      AluB             = op_q ? ~b_word : b_word;
      AluIFlags[FlagC] = carry_q;
    end
  end

  assign AluFuncOp = AddOp;
  assign Busy      = busy_q;
  assign Done      = done_q;
  assign AluOE     = alu_oe_q;
  assign Result    = result_q;
  assign Flags     = flags_q;

  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    carry_d    = carry_q;
    zero_acc_d = zero_acc_q;
    result_d   = result_q;
    flags_d    = flags_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    alu_oe_d   = alu_oe_q;

    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        alu_oe_d = 1'b1;
        if (Start) begin
          a_d        = OpA;
          b_d        = OpB;
          op_d       = Op;
          index_d    = '0;
          // A carry-in of 1 supplies the +1 of the two's-complement subtract.
          carry_d    = Op;
          zero_acc_d = 1'b1;
          state_d    = EXEC;
          busy_d     = 1'b1;
          alu_oe_d   = 1'b0;
        end
      end

      EXEC: begin
        for (int w = 0; w < Words; w++) begin
          if (index_q == IdxW'(w)) begin
            result_d[w*BitWidth +: BitWidth] = AluY;
          end
        end
        carry_d    = AluOFlags[FlagC];
        zero_acc_d = zero_acc_q & AluOFlags[FlagZ];
        if (last_word) begin
          // V and N are only meaningful for the most significant word.
          // Z must cover every word, so it comes from the accumulator.
          flags_d        = '0;
          flags_d[FlagV] = AluOFlags[FlagV];
          flags_d[FlagN] = AluOFlags[FlagN];
          flags_d[FlagC] = AluOFlags[FlagC];
          flags_d[FlagZ] = zero_acc_q & AluOFlags[FlagZ];
          state_d        = DONE;
          busy_d         = 1'b0;
          done_d         = 1'b1;
          alu_oe_d       = 1'b1;
        end else begin
          index_d = index_q + IdxW'(1);
        end
      end

      DONE: begin
        // Start is not looked at here. A request made during DONE is seen
        // only after the return to IDLE.
        state_d  = IDLE;
        busy_d   = 1'b0;
        alu_oe_d = 1'b1;
      end

      default: begin
        state_d  = IDLE;
        busy_d   = 1'b0;
        alu_oe_d = 1'b1;
      end
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q    <= IDLE;
      index_q    <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      carry_q    <= 1'b0;
      zero_acc_q <= 1'b0;
      result_q   <= '0;
      flags_q    <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      alu_oe_q   <= 1'b1;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      carry_q    <= carry_d;
      zero_acc_q <= zero_acc_d;
      result_q   <= result_d;
      flags_q    <= flags_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      alu_oe_q   <= alu_oe_d;
    end
  end

endmodule
